// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED display-sharing arbiters.
// Contents:
//   arb_state_t       ownership state of the display (idle / minimum slice running / preemptible)
//   IDLE_VAL_DEFAULT  value shown on the LEDs when nobody owns the display
//   clog2, idx_width  constant helpers for sizing pointers and counters
package led_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } arb_state_t;

  localparam logic [7:0] IDLE_VAL_DEFAULT = 8'h00;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Width needed to hold 0..value-1, never less than one bit.
  function automatic int idx_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/led_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches the candidate vector (req with the exclude mask removed) starting at
// position ptr and wrapping around, and returns the first hit as a one-hot pick.
// Ports:
//   req      N     request vector
//   ptr      PW    index searched first
//   exclude  N     requesters that must not be picked (e.g. the current owner)
//   pick     N     one-hot winner, zero when nothing qualifies
//   valid    1     high when pick is non-zero
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic [N-1:0]  exclude,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [N-1:0]   cand;
  logic [2*N-1:0] cand_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] first_dbl;

  assign cand     = req & ~exclude;
  assign cand_dbl = {cand, cand};

  // Rotate the candidates so that position ptr lands on bit 0; a plain
  // lowest-set-bit search on the rotated vector is then a wrapping search.
  assign rot = N'(cand_dbl >> ptr);

  // Lowest set bit of the rotated candidates.
  always_comb begin
    first = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        first[k] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

  // Rotate the one-hot result back into requester numbering.
  assign first_dbl = {first, first} << ptr;
  assign pick      = N'(first_dbl >> N);

endmodule

// File: rtl/led_share_arbiter.sv
// Time-slicing arbiter sharing the 8-LED display bank between NREQ requesters.
// Grants are round-robin; a new owner keeps the display for at least HOLD_TICKS
// strobes of taps[TAP_SEL] before a waiting requester may take over, but may
// give it up voluntarily at any time by dropping its request.
// Ports:
//   clk      1        system clock
//   rst_n    1        asynchronous active-low reset
//   taps     NTAPS    timebase strobes, single-cycle pulses
//   req      NREQ     per-requester request level
//   data     NREQ*8   per-requester display byte, requester i at [8i+7:8i]
//   gnt      NREQ     one-hot grant, zero when idle
//   led_val  8        registered display value for the led8 driver
//   busy     1        high while any requester owns the display
module led_share_arbiter
  import led_arb_pkg::*;
#(
  parameter int         NREQ       = 4,
  parameter int         NTAPS      = 7,
  parameter int         TAP_SEL    = 4,
  parameter int         HOLD_TICKS = 3,
  parameter logic [7:0] IDLE_VAL   = IDLE_VAL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NTAPS-1:0]  taps,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        led_val,
  output logic              busy
);

  localparam int PW = idx_width(NREQ);
  localparam int CW = idx_width(HOLD_TICKS + 1);
  localparam logic [CW:0] HOLD_LIM = (CW + 1)'(HOLD_TICKS);
  localparam arb_state_t GRANT_STATE = (HOLD_TICKS == 0) ? ST_OPEN : ST_HOLD;

  arb_state_t      state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [7:0]      led_n;
  logic [PW-1:0]   ptr, ptr_n, pick_idx, next_ptr;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW:0]     cnt_inc;
  logic [NREQ-1:0] pick;
  logic            pick_valid;
  logic            tick;
  logic            owner_req;
  logic            take;
  logic            unused_taps;

  assign tick        = taps[TAP_SEL];
  assign unused_taps = ^taps;
  assign owner_req   = |(gnt & req);
  assign cnt_inc     = {1'b0, cnt} + (CW + 1)'(1);
  assign busy        = |gnt;

  // The pointer always sits just after the current owner, so excluding the
  // owner lets one picker serve both the idle search and every handover.
  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .exclude (gnt),
    .pick    (pick),
    .valid   (pick_valid)
  );

  // Index of the picked requester, used to advance the pointer past it.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = PW'(i);
      end
    end
    next_ptr = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
  end

  // Next-state logic. A voluntary release is evaluated before any slice
  // counting, so a tick arriving together with a release is simply dropped.
  // When the tick that completes the minimum slice arrives while someone else
  // is waiting, the handover happens on that same edge rather than a cycle
  // later in OPEN. Every new grant funnels through 'take', which clears the
  // counter, so a tick coinciding with the grant edge is never counted.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = ptr;
    cnt_n   = cnt;
    take    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        take = pick_valid;
      end
      ST_HOLD, ST_OPEN: begin
        if (!owner_req) begin
          if (pick_valid) begin
            take = 1'b1;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
          end
        end else begin
          if (state == ST_HOLD && tick) begin
            cnt_n = cnt_inc[CW-1:0];
            if (cnt_inc >= HOLD_LIM) begin
              state_n = ST_OPEN;
            end
          end
          if (state_n == ST_OPEN && pick_valid) begin
            take = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
    if (take) begin
      gnt_n   = pick;
      ptr_n   = next_ptr;
      cnt_n   = '0;
      state_n = GRANT_STATE;
    end
  end

  // Display value follows whoever will own the display after this edge, so
  // gnt and led_val always change together.
  always_comb begin
    led_n = IDLE_VAL;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_n[i]) begin
        led_n = data[8*i +: 8];
      end
    end
  end

  // State, grant, pointer, counter and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      led_val <= IDLE_VAL;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      led_val <= led_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Self-checking bench for led_share_arbiter (NREQ=4, TAP_SEL=4, HOLD_TICKS=3).
// A fixed table of vectors walks through the directed scenarios, a hand-written
// sequence exercises asynchronous reset mid-slice, and a long randomized run
// is compared against an integer-level reference model.
module tb_led_share_arbiter;

  localparam int NREQ       = 4;
  localparam int NTAPS      = 7;
  localparam int TAP_SEL    = 4;
  localparam int HOLD_TICKS = 3;
  localparam int NV         = 29;
  localparam logic [31:0] DA = 32'h44A52211;
  localparam logic [31:0] DB = 32'h44A5225A;

  typedef struct {
    logic [3:0]  req;
    logic        tick;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_led;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NTAPS-1:0]  taps;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        led_val;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  int         m_owner;
  int         m_ptr;
  int         m_slice;
  logic [7:0] m_led;

  vec_t vec [NV];

  led_share_arbiter #(
    .NREQ       (NREQ),
    .NTAPS      (NTAPS),
    .TAP_SEL    (TAP_SEL),
    .HOLD_TICKS (HOLD_TICKS),
    .IDLE_VAL   (8'h00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .taps    (taps),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .led_val (led_val),
    .busy    (busy)
  );

  // Free-running system clock, 10 ns period.
  always #5 clk = ~clk;

  function automatic bit bit_of(input logic [NREQ-1:0] r, input int i);
    return ((r >> i) & 4'b0001) != 4'b0000;
  endfunction

  // First requesting index at or after 'from' (wrapping), skipping 'skip'.
  function automatic int next_pending(input logic [NREQ-1:0] r, input int from, input int skip);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (from + k) % NREQ;
      if (c != skip && bit_of(r, c)) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_gnt();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_slice = 0;
    m_led   = 8'h00;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % NREQ;
    m_slice = 0;
  endtask

  // Reference model: one clock edge of the ownership rules, written in terms
  // of owner index and number of slice ticks seen.
  task automatic model_edge(input logic [3:0] r, input logic t, input logic [31:0] d);
    int nxt;
    if (m_owner < 0) begin
      nxt = next_pending(r, m_ptr, -1);
      if (nxt >= 0) model_grant(nxt);
    end else if (!bit_of(r, m_owner)) begin
      nxt = next_pending(r, m_owner + 1, m_owner);
      if (nxt >= 0) model_grant(nxt);
      else begin
        m_owner = -1;
        m_slice = 0;
      end
    end else begin
      if (t && m_slice < HOLD_TICKS) m_slice = m_slice + 1;
      if (m_slice >= HOLD_TICKS) begin
        nxt = next_pending(r, m_owner + 1, m_owner);
        if (nxt >= 0) model_grant(nxt);
      end
    end
    m_led = (m_owner >= 0) ? 8'(d >> (8 * m_owner)) : 8'h00;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic t, input logic [31:0] d,
                              input logic [3:0] g, input logic [7:0] l);
    vec_t v;
    v.req = r; v.tick = t; v.data = d; v.exp_gnt = g; v.exp_led = l;
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, and move to 1 ns after the edge.
  task automatic applyStimulus(input logic [3:0] r, input logic t, input logic [31:0] d);
    logic [NTAPS-1:0] noise;
    noise          = NTAPS'($urandom);
    noise[TAP_SEL] = t;
    req  = r;
    data = d;
    taps = noise;
    model_edge(r, t, d);
    @(posedge clk);
    #1;
    taps = '0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_gnt, input logic [7:0] exp_led);
    n_vec++;
    if (gnt !== exp_gnt || led_val !== exp_led || busy !== (|exp_gnt)) begin
      n_err++;
      $display("[TB] FAIL %s: got gnt=%b led_val=%h busy=%b, expected gnt=%b led_val=%h busy=%b",
               name, gnt, led_val, busy, exp_gnt, exp_led, |exp_gnt);
    end
  endtask

  // Main test sequence.
  initial begin
    logic [3:0]  r;
    logic        t;
    logic [31:0] d;

    vec[0]  = mk(4'b0100, 1'b0, DA, 4'b0100, 8'hA5);
    vec[1]  = mk(4'b0000, 1'b0, DA, 4'b0000, 8'h00);
    vec[2]  = mk(4'b0011, 1'b1, DA, 4'b0001, 8'h11);
    vec[3]  = mk(4'b0011, 1'b1, DA, 4'b0001, 8'h11);
    vec[4]  = mk(4'b0011, 1'b0, DA, 4'b0001, 8'h11);
    vec[5]  = mk(4'b0011, 1'b1, DA, 4'b0001, 8'h11);
    vec[6]  = mk(4'b0011, 1'b1, DA, 4'b0010, 8'h22);
    vec[7]  = mk(4'b0000, 1'b0, DA, 4'b0000, 8'h00);
    vec[8]  = mk(4'b1000, 1'b0, DA, 4'b1000, 8'h44);
    vec[9]  = mk(4'b0001, 1'b1, DA, 4'b0001, 8'h11);
    vec[10] = mk(4'b1111, 1'b1, DA, 4'b0001, 8'h11);
    vec[11] = mk(4'b1111, 1'b1, DA, 4'b0001, 8'h11);
    vec[12] = mk(4'b1111, 1'b1, DA, 4'b0010, 8'h22);
    vec[13] = mk(4'b1111, 1'b1, DA, 4'b0010, 8'h22);
    vec[14] = mk(4'b1111, 1'b0, DA, 4'b0010, 8'h22);
    vec[15] = mk(4'b1111, 1'b1, DA, 4'b0010, 8'h22);
    vec[16] = mk(4'b1111, 1'b1, DA, 4'b0100, 8'hA5);
    vec[17] = mk(4'b1111, 1'b1, DA, 4'b0100, 8'hA5);
    vec[18] = mk(4'b1111, 1'b1, DA, 4'b0100, 8'hA5);
    vec[19] = mk(4'b1111, 1'b1, DA, 4'b1000, 8'h44);
    vec[20] = mk(4'b1111, 1'b1, DA, 4'b1000, 8'h44);
    vec[21] = mk(4'b1111, 1'b1, DA, 4'b1000, 8'h44);
    vec[22] = mk(4'b1111, 1'b1, DA, 4'b0001, 8'h11);
    vec[23] = mk(4'b1111, 1'b0, DB, 4'b0001, 8'h5A);
    vec[24] = mk(4'b0001, 1'b1, DB, 4'b0001, 8'h5A);
    vec[25] = mk(4'b0001, 1'b1, DB, 4'b0001, 8'h5A);
    vec[26] = mk(4'b0001, 1'b1, DB, 4'b0001, 8'h5A);
    vec[27] = mk(4'b0001, 1'b1, DB, 4'b0001, 8'h5A);
    vec[28] = mk(4'b0011, 1'b0, DB, 4'b0010, 8'h22);

    rst_n = 1'b0;
    req   = '0;
    taps  = '0;
    data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 4'b0000, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vec[i].req, vec[i].tick, vec[i].data);
      checkOutput($sformatf("vec%0d", i), vec[i].exp_gnt, vec[i].exp_led);
    end

    applyStimulus(4'b0100, 1'b0, DB);
    checkOutput("release_handover_to_2", 4'b0100, 8'hA5);
    applyStimulus(4'b0100, 1'b1, DB);
    checkOutput("hold_owner_2", 4'b0100, 8'hA5);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset_mid_hold", 4'b0000, 8'h00);
    #2 rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b0, DB);
    checkOutput("first_grant_after_reset", 4'b0001, 8'h5A);

    r = 4'b0000;
    d = DA;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) d = $urandom();
      applyStimulus(r, t, d);
      checkOutput($sformatf("rand%0d", c), model_gnt(), m_led);
      if ($urandom_range(0, 499) == 0) begin
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput($sformatf("rand_reset%0d", c), 4'b0000, 8'h00);
        #2 rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
